// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction fetch sequencer: issues word fetches to imem
// over req/ack and hands each fetched instruction, tagged with its PC, to decode.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] INCR     = 32'd1,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [31:0]       instr_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic [31:0]       pc_current
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt;
    logic [XLEN-1:0]   out_nxt;
    logic [XLEN-1:0]   ipc_nxt;
    logic              transfer;

    assign transfer   = instr_valid && instr_ready;
    assign pc_current = pc;

    // Next-state and next-output computation; redirect overrides everything else.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        valid_nxt = instr_valid;
        out_nxt   = instr_out;
        ipc_nxt   = instr_pc;

        if (redirect_valid) begin
            pc_nxt    = redirect_target;
            valid_nxt = 1'b0;
            case (state)
                DRAIN: begin
                    state_nxt = DRAIN;
                    req_nxt   = 1'b1;
                end
                REQ: begin
                    req_nxt = 1'b1;
                    if (imem_ack) begin
                        state_nxt = REQ;
                        addr_nxt  = redirect_target[ADDR_W-1:0];
                    end else begin
                        // outstanding fetch must complete at its original address
                        state_nxt = DRAIN;
                    end
                end
                default: begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = redirect_target[ADDR_W-1:0];
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc[ADDR_W-1:0];
                end
                REQ: begin
                    if (imem_ack) begin
                        state_nxt = HOLD;
                        req_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        out_nxt   = imem_rdata;
                        ipc_nxt   = pc;
                        pc_nxt    = XLEN'(pc + INCR);
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        state_nxt = REQ;
                        valid_nxt = 1'b0;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc[ADDR_W-1:0];
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_nxt = REQ;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc[ADDR_W-1:0];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC[ADDR_W-1:0];
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr_valid <= valid_nxt;
            instr_out   <= out_nxt;
            instr_pc    <= ipc_nxt;
        end
    end

endmodule
